sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Command/response engine for the SD-card SPI path. It takes one SD command (index plus 32-bit argument), frames the 6-byte token with a computed CRC7, and streams it byte-by-byte into the SPI byte controller. It then polls the card for the R1 response and captures up to 4 trailing response bytes (R3/R7). It sits directly upstream of the SPI byte controller, replacing the fixed CMD0 shift-out with a general, CRC-correct command source.

## Interface
- NCR_MAX, 8: maximum number of 0xFF poll bytes sent while waiting for R1 (1..255).
- CLOCK50  in  1  system clock; all logic on its rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- CMD_STB  in  1  command request, sampled in IDLE only.
- CMD_IDX  in  6  command index.
- CMD_ARG  in  32  command argument.
- CMD_RLEN  in  3  extra response bytes after R1 (0 = R1, 4 = R3/R7); values >4 are treated as 4.
- CMD_ACK  out  1  one-cycle pulse when a request is accepted.
- BUSY  out  1  high from acceptance until the DONE cycle, inclusive.
- DONE  out  1  one-cycle pulse at end of transaction.
- TIMEOUT  out  1  valid with DONE; 1 = no R1 received within NCR_MAX bytes.
- R1  out  8  R1 byte, valid from DONE until the next acceptance.
- RESP_EXT  out  32  extra response bytes, MSB-first and right-aligned; unused upper bytes are 0.
- TX_STB  out  1  byte valid to the SPI controller.
- TX_DATA  out  8  byte to transmit.
- TX_ACK  in  1  SPI controller accepted TX_DATA.
- RX_STB  in  1  one-cycle pulse: received byte valid.
- RX_DATA  in  8  received byte.
- CS  out  1  card chip select, active-low.

## Operation
- **States:** IDLE, CRC, SEND, POLL, EXT, FIN.
- **IDLE:** CMD_STB=1 latches CMD_IDX, CMD_ARG and CMD_RLEN, pulses CMD_ACK, and moves to CRC.
- **CRC:** Computes CRC7 serially over the 40 bits {2'b01, CMD_IDX, CMD_ARG}, MSB first, one bit per clock. Polynomial is x^7+x^3+1 and the register is cleared at entry. This takes exactly 40 cycles, then moves to SEND.
- **SEND:** Drives CS=0 and sends 6 bytes: {2'b01,IDX}, ARG[31:24], ARG[23:16], ARG[15:8], ARG[7:0], {CRC7,1'b1}. RX bytes received during SEND are discarded.
- **POLL:** Sends 0xFF repeatedly. The first RX byte with bit7=0 is stored to R1; go to EXT if RLEN>0, else FIN.
  - If NCR_MAX poll bytes all return bit7=1: R1=0xFF, TIMEOUT=1, skip EXT, go to FIN.
- **EXT:** Sends RLEN bytes of 0xFF. Each RX byte is shifted into RESP_EXT from the LSB side (RESP_EXT = {RESP_EXT[23:0], RX_DATA}).
- **FIN:** Drives CS=1 and sends one 0xFF byte (8 trailing card clocks). On its RX, pulses DONE and returns to IDLE.
- **Lockstep byte protocol:** The engine never issues the next byte until the RX_STB for the previous byte has arrived. Exactly one RX byte is expected per TX byte.
- **Stray traffic:** RX_STB while no byte is outstanding is ignored.
- **Busy requests:** CMD_STB outside IDLE is ignored, with no CMD_ACK.
- **Field clearing:** R1, RESP_EXT and TIMEOUT are cleared at acceptance.

## Timing
- **Reset values:** TX_STB=0, TX_DATA=0xFF, CS=1, CMD_ACK=0, BUSY=0, DONE=0, TIMEOUT=0, R1=0xFF, RESP_EXT=0; state IDLE.
- **Reset mid-operation:** Immediate return to IDLE with the above values. An in-flight SPI byte is abandoned and its RX is ignored.
- **TX handshake:**
  - TX_STB rises with TX_DATA valid, and both stay stable until TX_ACK=1 is sampled.
  - TX_STB drops the cycle after TX_ACK.
  - TX_ACK while TX_STB=0 is ignored.
- **RX_STB coincident with TX_ACK:** Accepted as that byte's response.
- **Acceptance:** CMD_STB sampled at edge k gives CMD_ACK=1 and BUSY=1 in cycle k+1.
- **First byte:** TX_STB for the first byte is asserted 40 cycles after entering CRC.
- **Next byte:** TX_STB for each subsequent byte is asserted the cycle after the previous RX_STB.
- **CS timing:** CS falls together with the first TX_STB of SEND and rises together with the FIN byte's TX_STB.
- **Completion:** DONE is asserted the cycle after the FIN byte's RX_STB. BUSY drops with DONE, and a new CMD_STB is accepted the next cycle.
- **Poll counter:** 8 bits, counting poll bytes issued. Timeout is declared on the RX of byte NCR_MAX, with no wrap.

## Test plan
- **CMD0:** CMD0, ARG=0, RLEN=0; SPI model returns FF,FF,01 to the polls -> TX bytes 40 00 00 00 00 95, FF, FF, FF, then FIN FF; R1=0x01, TIMEOUT=0, DONE once, CS low only from SEND to FIN.
- **CMD8:** CMD8, ARG=0x000001AA, RLEN=4; card returns 01 then 00 00 01 AA -> CRC byte 0x87, R1=0x01, RESP_EXT=0x000001AA.
- **CRC spot checks:** CMD55 ARG=0 -> last byte 0x65; ACMD41 (IDX 41) ARG=0x40000000 -> last byte 0x77.
- **Timeout:** NCR_MAX=8 and card always returns FF -> exactly 8 poll bytes, then FIN; R1=0xFF, TIMEOUT=1, RESP_EXT=0.
- **Backpressure and busy requests:** TX_ACK delayed 5 cycles on each byte, and CMD_STB pulsed during SEND -> TX_DATA stable while TX_STB=1, no CMD_ACK for the second request, byte sequence unchanged.
- **Reset mid-SEND:** RESET asserted after byte 3 -> TX_STB=0 and CS=1 immediately, BUSY=0; a fresh CMD0 then completes normally.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD-card SPI command engine: frames a command with CRC7,
// streams it to the byte controller and collects the R1/R3/R7 response.
module sd_cmd_engine #(
  parameter int NCR_MAX = 8
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        CMD_STB,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  input  logic [2:0]  CMD_RLEN,
  output logic        CMD_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [7:0]  R1,
  output logic [31:0] RESP_EXT,
  output logic        TX_STB,
  output logic [7:0]  TX_DATA,
  input  logic        TX_ACK,
  input  logic        RX_STB,
  input  logic [7:0]  RX_DATA,
  output logic        CS
);

  localparam logic [7:0] NcrMax = 8'(NCR_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CRC, S_SEND, S_POLL, S_EXT, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0]  rlen_q, rlen_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  poll_q, poll_d;
  logic [2:0]  ext_q, ext_d;
  logic        stb_q, stb_d;
  logic [7:0]  data_q, data_d;
  logic        pend_q, pend_d;
  logic        cs_q, cs_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] resp_q, resp_d;

  logic [39:0] frame;
  logic        crc_fb;
  logic [6:0]  crc_nxt;
  logic        rx_ok;
  logic        issue;
  logic [7:0]  issue_data;
  logic [7:0]  send_nxt;

  assign frame   = {2'b01, idx_q, arg_q};
  assign crc_fb  = frame[6'd39 - bit_q] ^ crc_q[6];
  assign crc_nxt = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};

  // An RX byte only counts while one of our bytes is outstanding and
  // the controller has taken it (or takes it in this same cycle).
  assign rx_ok = RX_STB && pend_q && (!stb_q || TX_ACK);

  // Next SEND byte after the one currently indexed by byte_q.
  always_comb begin
    send_nxt = {crc_q, 1'b1};
    unique case (byte_q)
      3'd0:    send_nxt = arg_q[31:24];
      3'd1:    send_nxt = arg_q[23:16];
      3'd2:    send_nxt = arg_q[15:8];
      3'd3:    send_nxt = arg_q[7:0];
      default: send_nxt = {crc_q, 1'b1};
    endcase
  end

  // Next-state logic: command latch, CRC, lockstep byte sequencing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    rlen_d     = rlen_q;
    crc_d      = crc_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    poll_d     = poll_q;
    ext_d      = ext_q;
    stb_d      = stb_q;
    data_d     = data_q;
    pend_d     = pend_q;
    cs_d       = cs_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    to_d       = to_q;
    r1_d       = r1_q;
    resp_d     = resp_q;
    issue      = 1'b0;
    issue_data = 8'hFF;

    if (stb_q && TX_ACK) stb_d = 1'b0;
    if (rx_ok) pend_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (CMD_STB && !done_q) begin
          idx_d   = CMD_IDX;
          arg_d   = CMD_ARG;
          rlen_d  = (CMD_RLEN > 3'd4) ? 3'd4 : CMD_RLEN;
          crc_d   = 7'd0;
          bit_d   = 6'd0;
          r1_d    = 8'hFF;
          resp_d  = 32'd0;
          to_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        crc_d = crc_nxt;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd39) begin
          state_d    = S_SEND;
          byte_d     = 3'd0;
          cs_d       = 1'b0;
          issue      = 1'b1;
          issue_data = {2'b01, idx_q};
        end
      end
      S_SEND: begin
        if (rx_ok) begin
          issue = 1'b1;
          if (byte_q == 3'd5) begin
            state_d = S_POLL;
            poll_d  = 8'd1;
          end else begin
            byte_d     = byte_q + 3'd1;
            issue_data = send_nxt;
          end
        end
      end
      S_POLL: begin
        if (rx_ok) begin
          issue = 1'b1;
          if (!RX_DATA[7]) begin
            r1_d = RX_DATA;
            if (rlen_q != 3'd0) begin
              state_d = S_EXT;
              ext_d   = 3'd1;
            end else begin
              state_d = S_FIN;
              cs_d    = 1'b1;
            end
          end else if (poll_q == NcrMax) begin
            r1_d    = 8'hFF;
            to_d    = 1'b1;
            state_d = S_FIN;
            cs_d    = 1'b1;
          end else begin
            poll_d = poll_q + 8'd1;
          end
        end
      end
      S_EXT: begin
        if (rx_ok) begin
          issue  = 1'b1;
          resp_d = {resp_q[23:0], RX_DATA};
          if (ext_q == rlen_q) begin
            state_d = S_FIN;
            cs_d    = 1'b1;
          end else begin
            ext_d = ext_q + 3'd1;
          end
        end
      end
      S_FIN: begin
        if (rx_ok) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      stb_d  = 1'b1;
      data_d = issue_data;
      pend_d = 1'b1;
    end
  end

  // State registers; reset abandons any in-flight byte.
  always_ff @(posedge CLOCK50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      arg_q   <= 32'd0;
      rlen_q  <= 3'd0;
      crc_q   <= 7'd0;
      bit_q   <= 6'd0;
      byte_q  <= 3'd0;
      poll_q  <= 8'd0;
      ext_q   <= 3'd0;
      stb_q   <= 1'b0;
      data_q  <= 8'hFF;
      pend_q  <= 1'b0;
      cs_q    <= 1'b1;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      r1_q    <= 8'hFF;
      resp_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      rlen_q  <= rlen_d;
      crc_q   <= crc_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      poll_q  <= poll_d;
      ext_q   <= ext_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      to_q    <= to_d;
      r1_q    <= r1_d;
      resp_q  <= resp_d;
    end
  end

  assign CMD_ACK  = ack_q;
  assign BUSY     = (state_q != S_IDLE) || done_q;
  assign DONE     = done_q;
  assign TIMEOUT  = to_q;
  assign R1       = r1_q;
  assign RESP_EXT = resp_q;
  assign TX_STB   = stb_q;
  assign TX_DATA  = data_q;
  assign CS       = cs_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a lockstep SPI byte model.
// Card responses come from rx_q; bytes sent are logged with CS.
module tb_sd_cmd_engine;

  logic        CLOCK50 = 1'b0;
  logic        RESET;
  logic        CMD_STB;
  logic [5:0]  CMD_IDX;
  logic [31:0] CMD_ARG;
  logic [2:0]  CMD_RLEN;
  logic        CMD_ACK, BUSY, DONE, TIMEOUT;
  logic [7:0]  R1;
  logic [31:0] RESP_EXT;
  logic        TX_STB;
  logic [7:0]  TX_DATA;
  logic        TX_ACK, RX_STB;
  logic [7:0]  RX_DATA;
  logic        CS;

  int n_chk = 0;
  int n_err = 0;
  int stab_err = 0;
  int rx_cnt = 0;
  int ack_dly = 1;
  bit aborted = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  logic       cs_log[$];

  sd_cmd_engine #(.NCR_MAX(8)) dut (
    .CLOCK50  (CLOCK50),
    .RESET    (RESET),
    .CMD_STB  (CMD_STB),
    .CMD_IDX  (CMD_IDX),
    .CMD_ARG  (CMD_ARG),
    .CMD_RLEN (CMD_RLEN),
    .CMD_ACK  (CMD_ACK),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .TIMEOUT  (TIMEOUT),
    .R1       (R1),
    .RESP_EXT (RESP_EXT),
    .TX_STB   (TX_STB),
    .TX_DATA  (TX_DATA),
    .TX_ACK   (TX_ACK),
    .RX_STB   (RX_STB),
    .RX_DATA  (RX_DATA),
    .CS       (CS)
  );

  always #5 CLOCK50 = ~CLOCK50;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SPI byte controller + card model
  initial begin
    logic [7:0] b;
    TX_ACK = 1'b0;
    RX_STB = 1'b0;
    RX_DATA = 8'h00;
    forever begin
      @(negedge CLOCK50);
      if (TX_STB) begin
        b = TX_DATA;
        tx_log.push_back(b);
        cs_log.push_back(CS);
        repeat (ack_dly) begin
          @(negedge CLOCK50);
          if (!aborted && (TX_STB !== 1'b1 || TX_DATA !== b))
            stab_err++;
        end
        TX_ACK = 1'b1;
        @(negedge CLOCK50);
        TX_ACK = 1'b0;
        RX_DATA = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
        RX_STB = 1'b1;
        rx_cnt++;
        @(negedge CLOCK50);
        RX_STB = 1'b0;
      end
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [2:0] rlen);
    tx_log.delete();
    cs_log.delete();
    @(posedge CLOCK50); #1;
    CMD_IDX = idx;
    CMD_ARG = arg;
    CMD_RLEN = rlen;
    CMD_STB = 1'b1;
    @(posedge CLOCK50); #1;
    CMD_STB = 1'b0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [2:0] rlen, input bit poke,
                         input string tag, input logic [7:0] e_r1,
                         input logic e_to, input logic [31:0] e_resp);
    int n;
    int dones;
    int acks;
    bit poked;
    start_cmd(idx, arg, rlen);
    chk({tag, ":ack"}, CMD_ACK, 1);
    chk({tag, ":busy"}, BUSY, 1);
    chk({tag, ":fld_to"}, TIMEOUT, 0);
    n = 0;
    while (!TX_STB && n < 100) begin
      @(posedge CLOCK50); #1;
      n++;
    end
    chk({tag, ":lat"}, n, 40);
    chk({tag, ":cs_lo"}, CS, 0);
    dones = 0;
    acks = 0;
    poked = 1'b0;
    n = 0;
    while (dones == 0 && n < 2000) begin
      if (poke && !poked && tx_log.size() == 2) begin
        CMD_STB = 1'b1;
        poked = 1'b1;
      end
      @(posedge CLOCK50); #1;
      CMD_STB = 1'b0;
      n++;
      if (CMD_ACK) acks++;
      if (DONE) dones++;
    end
    chk({tag, ":done"}, dones, 1);
    chk({tag, ":xack"}, acks, 0);
    chk({tag, ":busy_d"}, BUSY, 1);
    chk({tag, ":r1"}, R1, e_r1);
    chk({tag, ":to"}, TIMEOUT, e_to);
    chk({tag, ":resp"}, RESP_EXT, e_resp);
    chk({tag, ":cs_hi"}, CS, 1);
    @(posedge CLOCK50); #1;
    chk({tag, ":done1"}, DONE, 0);
    chk({tag, ":idle"}, BUSY, 0);
    chk({tag, ":ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("%s:tx%0d", tag, i), tx_log[i], exp_tx[i]);
    for (int i = 0; i < cs_log.size(); i++)
      chk($sformatf("%s:cs%0d", tag, i), cs_log[i],
          (i == cs_log.size() - 1) ? 1 : 0);
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    CMD_STB = 1'b0;
    CMD_IDX = 6'd0;
    CMD_ARG = 32'd0;
    CMD_RLEN = 3'd0;
    repeat (3) @(posedge CLOCK50);
    #1;
    chk("rst:tx_stb", TX_STB, 0);
    chk("rst:tx_data", TX_DATA, 8'hFF);
    chk("rst:cs", CS, 1);
    chk("rst:flags", {CMD_ACK, BUSY, DONE, TIMEOUT}, 0);
    chk("rst:r1", R1, 8'hFF);
    chk("rst:resp", RESP_EXT, 0);
    RESET = 1'b0;

    // CMD0, R1 after two idle polls
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'h01};
    exp_tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(6'd0, 32'd0, 3'd0, 1'b0, "cmd0", 8'h01, 1'b0, 32'd0);

    // CMD8 with R7 tail
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    exp_tx = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(6'd8, 32'h000001AA, 3'd4, 1'b0, "cmd8", 8'h01, 1'b0,
            32'h000001AA);

    // CMD55 CRC
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    exp_tx = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65,
               8'hFF, 8'hFF};
    run_cmd(6'd55, 32'd0, 3'd0, 1'b0, "cmd55", 8'h01, 1'b0, 32'd0);

    // ACMD41 CRC, RLEN=6 clamps to 4 tail bytes
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
    exp_tx = '{8'h69, 8'h40, 8'h00, 8'h00, 8'h00, 8'h77,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(6'd41, 32'h40000000, 3'd6, 1'b0, "acmd41", 8'h00, 1'b0,
            32'hC0FF8000);

    // Timeout: card never answers
    rx_q.delete();
    exp_tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'hFF};
    run_cmd(6'd0, 32'd0, 3'd0, 1'b0, "tmo", 8'hFF, 1'b1, 32'd0);

    // Backpressure and request while busy
    ack_dly = 5;
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'h01};
    exp_tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(6'd0, 32'd0, 3'd0, 1'b1, "bp", 8'h01, 1'b0, 32'd0);
    ack_dly = 1;

    // Reset in the middle of SEND
    rx_q.delete();
    start_cmd(6'd0, 32'd0, 3'd0);
    n = 0;
    while (rx_cnt_since() < 3 && n < 1000) begin
      @(posedge CLOCK50); #1;
      n++;
    end
    chk("mid:reach", (n < 1000) ? 1 : 0, 1);
    @(posedge CLOCK50); #1;
    chk("mid:inflight", TX_STB, 1);
    aborted = 1'b1;
    RESET = 1'b1;
    #1;
    chk("mid:tx_stb", TX_STB, 0);
    chk("mid:cs", CS, 1);
    chk("mid:busy", BUSY, 0);
    @(posedge CLOCK50); #1;
    RESET = 1'b0;
    repeat (30) @(posedge CLOCK50);
    chk("mid:quiet", {TX_STB, BUSY, DONE}, 0);
    aborted = 1'b0;
    rx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'h01};
    exp_tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(6'd0, 32'd0, 3'd0, 1'b0, "post", 8'h01, 1'b0, 32'd0);

    chk("stable", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Bytes answered since the current command started.
  function automatic int rx_cnt_since();
    return tx_log.size() - (TX_STB ? 1 : 0);
  endfunction

endmodule
